// File: rtl/link_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : link_scheduler
// Purpose  : Schedules the power board's serial links. Once per PERIOD cycles
//            it snapshots the outgoing SMPS (24-bit) and ESP32 (16-bit)
//            control frames and sends them MSB byte first through one shared
//            byte transmitter, steering it with tx_sel_o. Separately, it
//            rebuilds 3-byte SMPS telemetry frames from the receiver byte
//            stream and drops partial frames that go quiet.
//
// Build option : LINK_SCHEDULER_ESP_EN
//            defined   -> round = SMPS x3, one gap cycle, ESP x2
//            undefined -> round = SMPS x3 only, tx_sel_o tied 0,
//                         esp_frame_i ignored
//
// Parameters :
//   PERIOD      cycles per transmit round (16 .. 2^20)
//   RX_TIMEOUT  idle cycles allowed between bytes of one RX frame (4 .. 2^16)
//
// Ports :
//   clk, rst_n        clock (rising edge) / async active-low reset
//   smps_frame_i      SMPS frame, sampled at round start
//   esp_frame_i       ESP32 frame, sampled at round start
//   tx_data_o         byte to transmitter
//   tx_valid_o        byte valid, held until tx_ready_i
//   tx_ready_i        transmitter accepts byte
//   tx_sel_o          link steering: 0 = SMPS, 1 = ESP32
//   rx_data_i         byte from SMPS receiver
//   rx_valid_i        one-cycle strobe for rx_data_i
//   smps_rx_o         last complete received frame
//   smps_rx_valid_o   one-cycle pulse, smps_rx_o updated
//   rx_err_o          one-cycle pulse, partial frame discarded
//   overrun_o         one-cycle pulse, period tick during an active round
//   busy_o            FSM not idle
//
// Revision : 1.0  initial release
// ============================================================================
module link_scheduler #(
    parameter int PERIOD     = 50000,
    parameter int RX_TIMEOUT = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] smps_frame_i,
    input  logic [15:0] esp_frame_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_sel_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [23:0] smps_rx_o,
    output logic        smps_rx_valid_o,
    output logic        rx_err_o,
    output logic        overrun_o,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam int TO_W  = $clog2(RX_TIMEOUT);

    localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RX_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Free-running period counter
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] period_cnt_q;
    logic             tick;

    assign tick = (period_cnt_q == TICK_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
        end else if (tick) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
`ifdef LINK_SCHEDULER_ESP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SMPS = 2'd1,
        ST_GAP  = 2'd2,
        ST_ESP  = 2'd3
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SMPS = 1'b1
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] snap_smps_q;
    logic        load_snap;
    logic        overrun_q;

`ifdef LINK_SCHEDULER_ESP_EN
    logic [15:0] snap_esp_q;
`else
    // esp_frame_i has no sink in the SMPS-only build.
    logic unused_esp;
    assign unused_esp = ^esp_frame_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            snap_smps_q <= '0;
`ifdef LINK_SCHEDULER_ESP_EN
            snap_esp_q  <= '0;
`endif
            overrun_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            // A tick that lands mid-round is reported and dropped, not queued.
            overrun_q <= tick && (state_q != ST_IDLE);
            if (load_snap) begin
                snap_smps_q <= smps_frame_i;
`ifdef LINK_SCHEDULER_ESP_EN
                snap_esp_q  <= esp_frame_i;
`endif
            end
        end
    end

    // Outputs are decoded from registered state only, so tx_data_o cannot
    // move while a byte waits for tx_ready_i.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load_snap  = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        tx_sel_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    load_snap = 1'b1;
                    idx_d     = 2'd0;
                    state_d   = ST_SMPS;
                end
            end

            ST_SMPS: begin
                tx_valid_o = 1'b1;
                case (idx_q)
                    2'd0:    tx_data_o = snap_smps_q[23:16];
                    2'd1:    tx_data_o = snap_smps_q[15:8];
                    default: tx_data_o = snap_smps_q[7:0];
                endcase
                if (tx_ready_i) begin
                    if (idx_q == 2'd2) begin
                        idx_d = 2'd0;
`ifdef LINK_SCHEDULER_ESP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

`ifdef LINK_SCHEDULER_ESP_EN
            // One dead cycle with tx_sel already switched, so the steering
            // never changes under a valid byte.
            ST_GAP: begin
                tx_sel_o = 1'b1;
                state_d  = ST_ESP;
            end

            ST_ESP: begin
                tx_sel_o   = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = idx_q[0] ? snap_esp_q[7:0] : snap_esp_q[15:8];
                if (tx_ready_i) begin
                    if (idx_q[0]) begin
                        idx_d   = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = 2'd1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;

    // ------------------------------------------------------------------------
    // Receive frame assembler
    // ------------------------------------------------------------------------
    logic [1:0]      rx_cnt_q;
    logic [15:0]     rx_shift_q;
    logic [TO_W-1:0] rx_timer_q;
    logic [23:0]     smps_rx_q;
    logic            smps_rx_valid_q;
    logic            rx_err_q;

    // rx_timer_q counts cycles since the last strobe (1 in the cycle after
    // it), so rx_err_o rises exactly RX_TIMEOUT cycles after the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q        <= 2'd0;
            rx_shift_q      <= '0;
            rx_timer_q      <= '0;
            smps_rx_q       <= '0;
            smps_rx_valid_q <= 1'b0;
            rx_err_q        <= 1'b0;
        end else begin
            smps_rx_valid_q <= 1'b0;
            rx_err_q        <= 1'b0;
            if (rx_valid_i) begin
                rx_timer_q <= TO_W'(1);
                if (rx_cnt_q == 2'd2) begin
                    smps_rx_q       <= {rx_shift_q, rx_data_i};
                    smps_rx_valid_q <= 1'b1;
                    rx_cnt_q        <= 2'd0;
                end else begin
                    rx_shift_q <= {rx_shift_q[7:0], rx_data_i};
                    rx_cnt_q   <= rx_cnt_q + 2'd1;
                end
            end else if (rx_cnt_q != 2'd0) begin
                if (rx_timer_q == TO_LAST) begin
                    // Stale bytes in rx_shift_q are shifted out by the next
                    // frame before they can be used.
                    rx_cnt_q <= 2'd0;
                    rx_err_q <= 1'b1;
                end else begin
                    rx_timer_q <= rx_timer_q + TO_W'(1);
                end
            end
        end
    end

    assign smps_rx_o       = smps_rx_q;
    assign smps_rx_valid_o = smps_rx_valid_q;
    assign rx_err_o        = rx_err_q;

endmodule
`default_nettype wire

// File: doc/link_scheduler.md
# link_scheduler

Sequences the power board's serial links. Once per configurable period it snapshots the outgoing SMPS (24-bit) and ESP32 (16-bit) control frames and serialises them MSB-byte-first through a single shared byte transmitter, steering it with a select line. Independently, it reassembles 3-byte telemetry frames from the SMPS receiver into the 24-bit word consumed by the frame decoder. It sits between the encode/decode logic and the UART byte engines.

## Interface
- PERIOD, default 50000: cycles per transmit round; legal range 16..2^20.
- RX_TIMEOUT, default 2000: idle cycles allowed between bytes of one RX frame; legal range 4..2^16.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- smps_frame  in  24  outgoing SMPS frame; sampled only at round start.
- esp_frame  in  16  outgoing ESP32 frame; sampled only at round start.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready.
- tx_sel  out  1  link steering: 0 = SMPS, 1 = ESP32.
- rx_data  in  8  byte from SMPS receiver.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- smps_rx  out  24  last complete received frame.
- smps_rx_valid  out  1  one-cycle pulse, smps_rx updated.
- rx_err  out  1  one-cycle pulse, partial frame discarded on timeout.
- overrun  out  1  one-cycle pulse, period tick hit during active round.
- busy  out  1  high whenever FSM is not IDLE.

## Operation
- Period counter: 0..PERIOD-1, free-running, wraps; tick = (count == PERIOD-1).
- FSM states: IDLE, SMPS (3 bytes), GAP, ESP (2 bytes).
- IDLE + tick: latch smps_frame/esp_frame into snapshot registers, byte index 0, go SMPS.
- SMPS: tx_sel=0, tx_valid=1, tx_data = snapshot byte [23:16], then [15:8], then [7:0]; index advances only on handshake; after byte 2 handshake go GAP.
- GAP: tx_valid=0, tx_sel=1 for exactly one cycle, then ESP.
- ESP: tx_sel=1, tx_valid=1, bytes [15:8] then [7:0]; after byte 1 handshake go IDLE.
- tx_sel changes only in cycles where tx_valid=0 or after final handshake; tx_data stable while tx_valid && !tx_ready.
- Tick while not IDLE: assert overrun for one cycle; round not queued; current round unaffected.
- RX assembler: byte counter 0..2, shift MSB first; on third rx_valid, smps_rx <= {b0,b1,b2}, smps_rx_valid pulses next cycle, counter to 0.
- RX timeout counter resets on every rx_valid; if counter nonzero and RX_TIMEOUT cycles elapse with no rx_valid: discard bytes, counter to 0, rx_err pulse; smps_rx unchanged.
- RX and TX are fully independent; simultaneous events are all honoured in the same cycle.

## Timing
- Reset values: tx_data=0, tx_valid=0, tx_sel=0, smps_rx=0, smps_rx_valid=0, rx_err=0, overrun=0, busy=0; FSM IDLE; all counters 0; snapshots 0.
- First tick at cycle PERIOD-1 after reset release; tx_valid high the following cycle.
- With tx_ready held 1: SMPS bytes on 3 consecutive cycles, 1 GAP cycle, ESP bytes on 2 cycles; round = 6 cycles, busy high 6 cycles.
- smps_rx_valid: 1 cycle after third rx_valid. rx_err: 1 cycle after timeout expiry.
- Reset mid-round or mid-frame: immediate abort to reset values; no partial byte/frame output.

## Configuration
- LINK_SCHEDULER_ESP_EN defined: full round as above.
- Undefined: GAP and ESP states removed; round ends after SMPS byte 2 handshake; tx_sel tied 0; esp_frame ignored; round = 3 cycles at tx_ready=1.

## Test plan
- PERIOD=16, tx_ready=1, smps_frame=0xA1B2C3, esp_frame=0x8E65 -> tx_valid rises cycle 16; bytes A1,B2,C3 (sel 0), one idle cycle, 8E,65 (sel 1); busy 6 cycles.
- tx_ready low 5 cycles on byte B2 -> tx_data holds B2, tx_valid stays 1; inputs changed mid-round do not alter transmitted bytes.
- tx_ready=0 across a whole period -> overrun pulses once at tick; no second round starts after completion until next tick.
- rx bytes 0x12,0x34,0x56 spaced 10 cycles -> smps_rx=0x123456, one smps_rx_valid pulse.
- RX_TIMEOUT=8: bytes 0x12,0x34 then silence -> rx_err pulse 8 cycles after 0x34; next 0xAA,0xBB,0xCC -> smps_rx=0xAABBCC.
- rst_n low during ESP byte and during second RX byte -> all outputs to reset values; clean round at next tick.
